// File: rtl/pack_pkg.sv
// Shared types and constants for the byte-to-coefficient packer.
// PACK_LITTLE_END_EN selects little-endian nibble order in the pack helpers.
package pack_pkg;

    localparam int COEF_W     = 12;
    localparam int BYTE_W     = 8;
    localparam int N_COEF_DEF = 16;

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } state_t;

    // Only one nibble of the middle byte survives into the second coefficient,
    // so that is all we keep of it.
    function automatic logic [3:0] keep_nib(input logic [BYTE_W-1:0] b);
`ifdef PACK_LITTLE_END_EN
        return b[7:4];
`else
        return b[3:0];
`endif
    endfunction

    function automatic logic [COEF_W-1:0] first_coef(
        input logic [BYTE_W-1:0] b0,
        input logic [BYTE_W-1:0] b1
    );
`ifdef PACK_LITTLE_END_EN
        return {b1[3:0], b0};
`else
        return {b0, b1[7:4]};
`endif
    endfunction

    function automatic logic [COEF_W-1:0] second_coef(
        input logic [3:0]        nib,
        input logic [BYTE_W-1:0] b2
    );
`ifdef PACK_LITTLE_END_EN
        return {b2, nib};
`else
        return {nib, b2};
`endif
    endfunction

endpackage

// File: rtl/pack_8a12.sv
// Packs every 3 input bytes into two 12-bit coefficients with a shift strobe.
// PACK_LITTLE_END_EN (via pack_pkg) selects little-endian nibble order.
import pack_pkg::*;

module pack_8a12 #(
    parameter int N_COEF = N_COEF_DEF,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    input  logic              clr,
    output logic [COEF_W-1:0] coef_out,
    output logic              enable_8a12,
    output logic [CNT_W-1:0]  coef_cnt,
    output logic              frame_done,
    output logic              overflow
);

    state_t              state;
    state_t              state_nxt;
    logic [BYTE_W-1:0]   b0;
    logic [BYTE_W-1:0]   b0_nxt;
    logic [3:0]          b1;
    logic [3:0]          b1_nxt;
    logic [COEF_W-1:0]   coef_nxt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                emit;
    logic                en_r;
    logic                take;
    logic                last;

    assign take    = byte_valid & ~frame_done;
    assign cnt_inc = coef_cnt + CNT_W'(1);
    assign last    = (cnt_inc == CNT_W'(N_COEF));

    // Next-state, byte capture and coefficient assembly.
    always_comb begin
        state_nxt = state;
        b0_nxt    = b0;
        b1_nxt    = b1;
        coef_nxt  = coef_out;
        emit      = 1'b0;
        if (take) begin
            case (state)
                S_B0: begin
                    b0_nxt    = byte_in;
                    state_nxt = S_B1;
                end
                S_B1: begin
                    b1_nxt    = keep_nib(byte_in);
                    coef_nxt  = first_coef(b0, byte_in);
                    emit      = 1'b1;
                    state_nxt = last ? S_B0 : S_B2;
                end
                S_B2: begin
                    coef_nxt  = second_coef(b1, byte_in);
                    emit      = 1'b1;
                    state_nxt = S_B0;
                end
                default: state_nxt = S_B0;
            endcase
        end
    end

    // State, output and frame bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= S_B0;
            b0         <= '0;
            b1         <= '0;
            coef_out   <= '0;
            en_r       <= 1'b0;
            coef_cnt   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state    <= state_nxt;
            b0       <= b0_nxt;
            b1       <= b1_nxt;
            coef_out <= coef_nxt;
            en_r     <= emit;
            if (emit) begin
                coef_cnt <= cnt_inc;
                if (last) frame_done <= 1'b1;
            end
            if (byte_valid && frame_done) overflow <= 1'b1;
        end
    end

    // A reset arriving while a strobe is on the wire kills that strobe.
    assign enable_8a12 = en_r & ~(rst | clr);

endmodule

// File: tb/tb_pack_8a12.sv
// Directed self-checking bench for pack_8a12.
// Expected values follow PACK_LITTLE_END_EN when it is defined.
module tb_pack_8a12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  bi = 8'h00;
    logic        bv = 1'b0;
    logic [11:0] coef;
    logic        en;
    logic [4:0]  cnt;
    logic        fd;
    logic        ov;

    logic        rst3 = 1'b1;
    logic        clr3 = 1'b0;
    logic [7:0]  bi3 = 8'h00;
    logic        bv3 = 1'b0;
    logic [11:0] coef3;
    logic        en3;
    logic [2:0]  cnt3;
    logic        fd3;
    logic        ov3;

    int total = 0;
    int bad   = 0;

`ifdef PACK_LITTLE_END_EN
    localparam logic [11:0] E1  = 12'h412;
    localparam logic [11:0] E2  = 12'h563;
    localparam logic [11:0] E01 = 12'h301;
    localparam logic [11:0] T1  = 12'h211;
    localparam logic [11:0] T2  = 12'h332;
    localparam logic [11:0] T3  = 12'h544;
`else
    localparam logic [11:0] E1  = 12'h123;
    localparam logic [11:0] E2  = 12'h456;
    localparam logic [11:0] E01 = 12'h012;
    localparam logic [11:0] T1  = 12'h112;
    localparam logic [11:0] T2  = 12'h233;
    localparam logic [11:0] T3  = 12'h445;
`endif

    always #5 clk = ~clk;

    pack_8a12 dut (
        .clk(clk), .rst(rst), .byte_in(bi), .byte_valid(bv), .clr(clr),
        .coef_out(coef), .enable_8a12(en), .coef_cnt(cnt),
        .frame_done(fd), .overflow(ov)
    );

    pack_8a12 #(.N_COEF(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst3), .byte_in(bi3), .byte_valid(bv3), .clr(clr3),
        .coef_out(coef3), .enable_8a12(en3), .coef_cnt(cnt3),
        .frame_done(fd3), .overflow(ov3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bv = 1'b1;
        bi = b;
        step();
        bv = 1'b0;
    endtask

    task automatic send3(input logic [7:0] b);
        bv3 = 1'b1;
        bi3 = b;
        step();
        bv3 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bv  = 1'b1;
        bi  = 8'hFF;
        step();
        step();
        total++; if (coef !== 12'h000) begin bad++; $display("FAIL rst_coef got=%h exp=000", coef); end
        total++; if (en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", en); end
        total++; if (cnt !== 5'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
        total++; if (fd !== 1'b0) begin bad++; $display("FAIL rst_fd got=%b exp=0", fd); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL rst_ov got=%b exp=0", ov); end
        rst = 1'b0;
        bv  = 1'b0;
    endtask

    task automatic test_basic();
        bv = 1'b1; bi = 8'h12; step();
        total++; if (en !== 1'b0) begin bad++; $display("FAIL b0_en got=%b exp=0", en); end
        bi = 8'h34; step();
        total++; if (en !== 1'b1) begin bad++; $display("FAIL c1_en got=%b exp=1", en); end
        total++; if (coef !== E1) begin bad++; $display("FAIL c1_coef got=%h exp=%h", coef, E1); end
        bi = 8'h56; step();
        bv = 1'b0;
        total++; if (en !== 1'b1) begin bad++; $display("FAIL c2_en got=%b exp=1", en); end
        total++; if (coef !== E2) begin bad++; $display("FAIL c2_coef got=%h exp=%h", coef, E2); end
        total++; if (cnt !== 5'd2) begin bad++; $display("FAIL c2_cnt got=%0d exp=2", cnt); end
        step();
        total++; if (en !== 1'b0) begin bad++; $display("FAIL idle_en got=%b exp=0", en); end
        total++; if (coef !== E2) begin bad++; $display("FAIL hold_coef got=%h exp=%h", coef, E2); end
    endtask

    task automatic test_frame();
        int n = 0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (cnt !== 5'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", cnt); end
        for (int i = 0; i < 24; i++) begin
            send(8'hAA);
            total++; if (en !== ((i % 3) != 0)) begin bad++; $display("FAIL fr_en i=%0d got=%b", i, en); end
            if ((i % 3) != 0) begin
                n++;
                total++; if (coef !== 12'hAAA) begin bad++; $display("FAIL fr_coef i=%0d got=%h exp=aaa", i, coef); end
            end
            total++; if (fd !== (n == 16)) begin bad++; $display("FAIL fr_fd i=%0d got=%b exp=%b", i, fd, n == 16); end
            for (int g = 0; g < (i % 4); g++) begin
                step();
                total++; if (en !== 1'b0) begin bad++; $display("FAIL gap_en i=%0d got=%b exp=0", i, en); end
            end
        end
        total++; if (cnt !== 5'd16) begin bad++; $display("FAIL fr_cnt got=%0d exp=16", cnt); end
        total++; if (fd !== 1'b1) begin bad++; $display("FAIL fr_done got=%b exp=1", fd); end
    endtask

    task automatic test_overflow();
        send(8'h77);
        total++; if (en !== 1'b0) begin bad++; $display("FAIL ov_en got=%b exp=0", en); end
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL ov_set got=%b exp=1", ov); end
        total++; if (cnt !== 5'd16) begin bad++; $display("FAIL ov_cnt got=%0d exp=16", cnt); end
        step();
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL ov_sticky got=%b exp=1", ov); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (cnt !== 5'd0) begin bad++; $display("FAIL oc_cnt got=%0d exp=0", cnt); end
        total++; if (fd !== 1'b0) begin bad++; $display("FAIL oc_fd got=%b exp=0", fd); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL oc_ov got=%b exp=0", ov); end
        send(8'h12);
        send(8'h34);
        total++; if (en !== 1'b1) begin bad++; $display("FAIL oc_en got=%b exp=1", en); end
        total++; if (coef !== E1) begin bad++; $display("FAIL oc_coef got=%h exp=%h", coef, E1); end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        send(8'hAB);
        bv = 1'b1; bi = 8'hCD;
        step();
        bv = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (en !== 1'b0) begin bad++; $display("FAIL rm_supp got=%b exp=0", en); end
        step();
        rst = 1'b0;
        total++; if (en !== 1'b0) begin bad++; $display("FAIL rm_en got=%b exp=0", en); end
        total++; if (cnt !== 5'd0) begin bad++; $display("FAIL rm_cnt got=%0d exp=0", cnt); end
        send(8'h01);
        send(8'h23);
        total++; if (en !== 1'b1) begin bad++; $display("FAIL rm_en2 got=%b exp=1", en); end
        total++; if (coef !== E01) begin bad++; $display("FAIL rm_coef got=%h exp=%h", coef, E01); end
    endtask

    task automatic test_ncoef3();
        step();
        rst3 = 1'b0;
        send3(8'h11);
        total++; if (en3 !== 1'b0) begin bad++; $display("FAIL n3_b0 got=%b exp=0", en3); end
        send3(8'h22);
        total++; if (en3 !== 1'b1 || coef3 !== T1) begin bad++; $display("FAIL n3_c1 got=%b/%h exp=1/%h", en3, coef3, T1); end
        send3(8'h33);
        total++; if (en3 !== 1'b1 || coef3 !== T2) begin bad++; $display("FAIL n3_c2 got=%b/%h exp=1/%h", en3, coef3, T2); end
        total++; if (fd3 !== 1'b0) begin bad++; $display("FAIL n3_fd2 got=%b exp=0", fd3); end
        send3(8'h44);
        total++; if (en3 !== 1'b0) begin bad++; $display("FAIL n3_b3 got=%b exp=0", en3); end
        send3(8'h55);
        total++; if (en3 !== 1'b1 || coef3 !== T3) begin bad++; $display("FAIL n3_c3 got=%b/%h exp=1/%h", en3, coef3, T3); end
        total++; if (fd3 !== 1'b1) begin bad++; $display("FAIL n3_fd got=%b exp=1", fd3); end
        total++; if (cnt3 !== 3'd3) begin bad++; $display("FAIL n3_cnt got=%0d exp=3", cnt3); end
        total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL n3_ov0 got=%b exp=0", ov3); end
        send3(8'h66);
        total++; if (en3 !== 1'b0) begin bad++; $display("FAIL n3_drop got=%b exp=0", en3); end
        total++; if (ov3 !== 1'b1) begin bad++; $display("FAIL n3_ov got=%b exp=1", ov3); end
        total++; if (coef3 !== T3) begin bad++; $display("FAIL n3_hold got=%h exp=%h", coef3, T3); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame();
        test_overflow();
        test_rst_mid();
        test_ncoef3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
